uart_cmd_parser: RTL and testbench

- Consumes bytes from the UART receiver (avail/data pair) and assembles fixed 5-byte command frames.
- Validates each frame and issues single-cycle register write or read-request strobes to the hardware-controller register file.
- Sits between the UART receive path and the register/peripheral bus. It is the only sequencer of received bytes.

---
 rtl/uart_cmd_defs.sv | 32 +++
 rtl/byte_strobe.sv | 30 +++
 rtl/uart_cmd_parser.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_defs.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_defs (package)
// Brief    : Shared constants for the UART command parser: frame marker,
//            opcodes, error codes and the 3-bit parser state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_defs;

  // Default frame start marker
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Command opcodes carried in the CMD byte
  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_READ      = 8'h02;

  // Values reported on err_code
  localparam logic [1:0] ERR_CSUM     = 2'd1;
  localparam logic [1:0] ERR_OPCODE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Parser state: which frame byte is expected next
  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_strobe.sv
`default_nettype none
// ============================================================================
// Module   : byte_strobe
// Brief    : Turns the receiver's byte-valid level into a one-cycle strobe on
//            its rising edge. The history register resets to 1 so a level
//            already high when reset releases is not mistaken for a new byte.
// Revision : 1.0 - initial release
// ============================================================================
module byte_strobe (
  input  logic clock,
  input  logic rst,
  input  logic rx_avail,
  output logic stb
);

  logic r_avail_q;

  // Remember last cycle's level of rx_avail for edge detection
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_avail_q <= 1'b1;
    end else begin
      r_avail_q <= rx_avail;
    end
  end

  assign stb = rx_avail & ~r_avail_q;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Assembles 5-byte frames (SYNC, CMD, ADDR, DATA, CSUM) from the
//            UART receiver, checks them and issues one-cycle write,
//            read-request or error strobes. An inter-byte timeout abandons
//            stalled frames.
//            Optional macro UART_CMD_PARSER_STATS_EN adds saturating frame and
//            error counters on ports frame_cnt / err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
  import uart_cmd_defs::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 25000,
  parameter int         TO_W        = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        rx_avail,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_en,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
`ifdef UART_CMD_PARSER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [TO_W-1:0] c_to_limit = TO_W'(TIMEOUT_CYC);

  state_t            r_state;
  logic [7:0]        r_cmd;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_stb;
  logic [7:0]        w_csum;

  byte_strobe u_byte_strobe (
    .clock    (clock),
    .rst      (rst),
    .rx_avail (rx_avail),
    .stb      (w_stb)
  );

  // Expected checksum of the frame assembled so far
  assign w_csum = r_cmd ^ wr_addr ^ wr_data;

  assign busy = (r_state != S_SYNC);

  // Frame sequencer, inter-byte timeout and registered strobe outputs
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state  <= S_SYNC;
      r_cmd    <= '0;
      r_to_cnt <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      err   <= 1'b0;
      if (r_state == S_SYNC) begin
        // Idle: timeout does not run, non-marker bytes are dropped silently
        r_to_cnt <= '0;
        if (w_stb && (rx_data == SYNC_BYTE)) begin
          r_state <= S_CMD;
        end
      end else if (w_stb) begin
        // A byte arriving in the same cycle as the timeout still counts
        r_to_cnt <= '0;
        case (r_state)
          S_CMD: begin
            r_cmd   <= rx_data;
            r_state <= S_ADDR;
          end
          S_ADDR: begin
            wr_addr <= rx_data;
            r_state <= S_DATA;
          end
          S_DATA: begin
            wr_data <= rx_data;
            r_state <= S_CSUM;
          end
          S_CSUM: begin
            r_state <= S_SYNC;
            if (rx_data != w_csum) begin
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end else if (r_cmd == OP_WRITE) begin
              wr_en <= 1'b1;
            end else if (r_cmd == OP_READ) begin
              rd_en <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_OPCODE;
            end
          end
          default: begin
            r_state <= S_SYNC;
          end
        endcase
      end else if (r_to_cnt == c_to_limit) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        r_state  <= S_SYNC;
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

`ifdef UART_CMD_PARSER_STATS_EN
  // Saturating counts of executed frames and reported errors
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if ((wr_en || rd_en) && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Self-checking bench for uart_cmd_parser. Directed frames from the
//            test plan followed by randomized frames, all compared against a
//            queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

  localparam logic [7:0] c_sync = 8'hA5;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        rx_avail = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        wr_en, rd_en, err, busy;
  logic [7:0]  wr_addr, wr_data;
  logic [1:0]  err_code;
`ifdef UART_CMD_PARSER_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  uart_cmd_parser dut (
    .clock    (clock),
    .rst      (rst),
    .rx_avail (rx_avail),
    .rx_data  (rx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .err      (err),
    .err_code (err_code),
    .busy     (busy)
`ifdef UART_CMD_PARSER_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the inactive edge
  int mon_wr = 0, mon_rd = 0, mon_err = 0, mon_overlap = 0;
  always @(negedge clock) begin
    if (wr_en) mon_wr++;
    if (rd_en) mon_rd++;
    if (err)   mon_err++;
    if ((int'(wr_en) + int'(rd_en) + int'(err)) > 1) mon_overlap++;
  end

  // Reference model: bytes of the frame in progress plus expected totals
  logic [7:0] mq[$];
  int         exp_wr = 0, exp_rd = 0, exp_err = 0;
  int         st_frames = 0, st_errs = 0;
  logic [7:0] exp_addr = 8'h00, exp_data = 8'h00;
  logic [1:0] exp_code = 2'd0;

  task automatic model_byte(input logic [7:0] b);
    if (mq.size() == 0) begin
      if (b == c_sync) mq.push_back(b);
    end else begin
      mq.push_back(b);
      if (mq.size() == 3) exp_addr = b;
      if (mq.size() == 4) exp_data = b;
      if (mq.size() == 5) begin
        if ((mq[1] ^ mq[2] ^ mq[3]) != mq[4]) begin
          exp_err++; st_errs++; exp_code = 2'd1;
        end else if (mq[1] == 8'h01) begin
          exp_wr++; st_frames++;
        end else if (mq[1] == 8'h02) begin
          exp_rd++; st_frames++;
        end else begin
          exp_err++; st_errs++; exp_code = 2'd2;
        end
        mq.delete();
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_addr = 8'h00; exp_data = 8'h00; exp_code = 2'd0;
    st_frames = 0; st_errs = 0;
  endtask

  task automatic check_state();
    check_val("wr_en_count", mon_wr, exp_wr);
    check_val("rd_en_count", mon_rd, exp_rd);
    check_val("err_count",   mon_err, exp_err);
    check_val("wr_addr",     {24'd0, wr_addr}, {24'd0, exp_addr});
    check_val("wr_data",     {24'd0, wr_data}, {24'd0, exp_data});
    check_val("err_code",    {30'd0, err_code}, {30'd0, exp_code});
    check_val("busy",        {31'd0, busy}, {31'd0, (mq.size() != 0)});
`ifdef UART_CMD_PARSER_STATS_EN
    check_val("frame_cnt",   {16'd0, frame_cnt}, st_frames);
    check_val("err_cnt",     {16'd0, err_cnt}, st_errs);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_avail = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clock);
    rx_avail = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(2, 5)) @(negedge clock);
    #2;
    model_byte(b);
    check_state();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] s);
    send_byte(c_sync);
    send_byte(c);
    send_byte(a);
    send_byte(d);
    send_byte(s);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    #2;
    check_state();
  endtask

  // Hard stop if the run ever stalls
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c, a, d, s;
    int kind;

    // Reset values
    repeat (3) @(negedge clock);
    #2;
    check_val("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("reset_rd_en", {31'd0, rd_en}, 32'd0);
    check_val("reset_err",   {31'd0, err}, 32'd0);
    check_val("reset_code",  {30'd0, err_code}, 32'd0);
    check_val("reset_busy",  {31'd0, busy}, 32'd0);
    check_val("reset_addr",  {24'd0, wr_addr}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clock);

    // Directed frames
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);   // write
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);   // read
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00);   // bad checksum
    send_frame(8'h01, 8'h44, 8'h55, 8'h10);   // valid write afterwards
    send_byte(8'h00);                          // garbage ignored
    send_byte(8'hFF);
    send_frame(8'h07, 8'h01, 8'h02, 8'h04);   // bad opcode

    // Timeout after partial frame
    send_byte(c_sync);
    send_byte(8'h01);
    repeat (24900) @(negedge clock);
    #2;
    check_state();                             // still waiting, no error yet
    repeat (200) @(negedge clock);
    #2;
    mq.delete();
    exp_err++; st_errs++; exp_code = 2'd3;
    check_state();
    send_frame(8'h02, 8'h5A, 8'h00, 8'h58);

    // rx_avail high across reset release is not a byte
    @(negedge clock);
    rst      = 1'b0;
    rx_data  = c_sync;
    rx_avail = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    model_reset();
    repeat (5) @(negedge clock);
    #2;
    check_state();
    rx_avail = 1'b0;
    repeat (2) @(negedge clock);
    send_frame(8'h01, 8'h33, 8'h77, 8'h45);

    // Reset mid-frame discards it silently
    send_byte(c_sync);
    send_byte(8'h01);
    send_byte(8'h10);
    do_reset();
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);

    // Randomized frames
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 4));
      a = ($urandom_range(0, 7) == 0) ? c_sync : 8'($urandom);
      d = ($urandom_range(0, 7) == 0) ? c_sync : 8'($urandom);
      case (kind)
        0: c = 8'h01;
        1: c = 8'h02;
        default: c = 8'($urandom);
      endcase
      s = c ^ a ^ d;
      if (kind == 2) s = s ^ 8'($urandom_range(1, 255));
      if (kind == 4) begin
        s = 8'($urandom);
        if (s == c_sync) s = 8'h00;
        send_byte(s);
      end else begin
        send_frame(c, a, d, s);
      end
    end

    check_val("strobe_overlap", mon_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
